// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHR   = 3'd1,
    MODE_SHL   = 3'd2,
    MODE_LOAD  = 3'd3,
    MODE_ROR   = 3'd4,
    MODE_ROL   = 3'd5,
    MODE_ASR   = 3'd6,
    MODE_BURST = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } burst_state_e;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller: counts a programmed number of right shifts, then parks in
// WAIT until MODE leaves BURST so a held MODE=7 never retriggers.
//
// state | meaning
// IDLE  | no burst; register follows MODE 0-6 directly
// RUN   | shifting right once per edge, counter holds shifts remaining
// WAIT  | burst finished (or zero length); register holds until MODE != 7
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_e            mode,
  input  logic [CNT_W-1:0] burst_len,
  output logic             burst_shift,
  output logic             busy,
  output logic             done
);

  burst_state_e     state;
  logic [CNT_W-1:0] count;

  // Shift strobe is only asserted while running and the burst is not being aborted.
  assign burst_shift = (state == RUN) && (mode == MODE_BURST);

  // Burst FSM with down-counter; busy and done are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mode == MODE_BURST) begin
            if (burst_len != '0) begin
              count <= burst_len;
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= WAIT;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mode != MODE_BURST) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state <= WAIT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (mode != MODE_BURST) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/usr_param.sv
// Parametrised universal shift register with hold, shifts, rotates, load and
// a counted right-shift burst driven by usr_burst_ctrl.
module usr_param
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Data,
  input  logic [2:0]       MODE,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [CNT_W-1:0] burst_len,
  output logic             serial_Q,
  output logic [WIDTH-1:0] parallel_Q,
  output logic             busy,
  output logic             done
);

  mode_e            mode;
  logic             burst_shift;
  logic [WIDTH-1:0] q_next;
  logic             sq_next;

  assign mode = mode_e'(MODE);

  usr_burst_ctrl #(.CNT_W(CNT_W)) u_burst_ctrl (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .burst_len   (burst_len),
    .burst_shift (burst_shift),
    .busy        (busy),
    .done        (done)
  );

  // Next-value mux; modes 0-6 act in any FSM state, which also covers the abort edge.
  always_comb begin
    q_next  = parallel_Q;
    sq_next = serial_Q;
    case (mode)
      MODE_HOLD: ;
      MODE_SHR: begin
        q_next  = {serial_in_r, parallel_Q[WIDTH-1:1]};
        sq_next = parallel_Q[0];
      end
      MODE_SHL: begin
        q_next  = {parallel_Q[WIDTH-2:0], serial_in_l};
        sq_next = parallel_Q[WIDTH-1];
      end
      MODE_LOAD: q_next = Data;
      MODE_ROR: begin
        q_next  = {parallel_Q[0], parallel_Q[WIDTH-1:1]};
        sq_next = parallel_Q[0];
      end
      MODE_ROL: begin
        q_next  = {parallel_Q[WIDTH-2:0], parallel_Q[WIDTH-1]};
        sq_next = parallel_Q[WIDTH-1];
      end
      MODE_ASR: begin
        q_next  = {parallel_Q[WIDTH-1], parallel_Q[WIDTH-1:1]};
        sq_next = parallel_Q[0];
      end
      MODE_BURST: begin
        if (burst_shift) begin
          q_next  = {serial_in_r, parallel_Q[WIDTH-1:1]};
          sq_next = parallel_Q[0];
        end
      end
      default: ;
    endcase
  end

  // Storage register and the registered serial output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_Q <= '0;
      serial_Q   <= 1'b0;
    end else begin
      parallel_Q <= q_next;
      serial_Q   <= sq_next;
    end
  end

endmodule

// File: doc/usr_param.md
# usr_param

Parametrised universal shift register: WIDTH-bit storage with hold, logical and arithmetic shifts, rotates and parallel load. It also has a counted burst mode that shifts right a programmed number of times, then stops and pulses `done`. It is the next-generation replacement for the fixed 4-bit universal shift register. It serves as the general serialiser/deserialiser element in sequential datapaths.

## Interface
- `WIDTH`, 8, register width; legal values are 2 or more.
- `CNT_W`, $clog2(WIDTH)+1, width of the burst length input and the internal counter.
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset; one clock domain only.
- `Data`  input  WIDTH  parallel load value.
- `MODE`  input  3  operation select (see Operation).
- `serial_in_r`  input  1  bit entering the MSB on a right shift.
- `serial_in_l`  input  1  bit entering the LSB on a left shift.
- `burst_len`  input  CNT_W  number of shifts for a burst; sampled on burst start only.
- `serial_Q`  output  1  registered copy of the last bit shifted or rotated out.
- `parallel_Q`  output  WIDTH  register contents.
- `busy`  output  1  high while the burst FSM is in RUN.
- `done`  output  1  one-cycle pulse when a burst completes.

## Operation
- `MODE` encoding:
  - 0 HOLD.
  - 1 SHR: {serial_in_r, Q[W-1:1]}.
  - 2 SHL: {Q[W-2:0], serial_in_l}.
  - 3 LOAD: Data.
  - 4 ROR: {Q[0], Q[W-1:1]}.
  - 5 ROL: {Q[W-2:0], Q[W-1]}.
  - 6 ASR: {Q[W-1], Q[W-1:1]}.
  - 7 BURST.
- Bit leaving the register:
  - Right-direction modes (1, 4, 6 and burst shifts): `serial_Q` <= Q[0].
  - Left-direction modes (2, 5): `serial_Q` <= Q[W-1].
  - HOLD and LOAD: `serial_Q` holds its value.
- Burst FSM states: IDLE, RUN, WAIT.
  - IDLE with MODE=7 and burst_len≠0: latch count=burst_len, go to RUN; no shift on this edge.
  - IDLE with MODE=7 and burst_len=0: go to WAIT and pulse `done`; no shift.
  - RUN: each edge performs SHR with serial_in_r and decrements count. On the edge where count=1 (last shift), go to WAIT and set `done` for the following cycle.
  - WAIT: register holds. Exit to IDLE only when MODE≠7, so a burst never retriggers while MODE stays 7.
  - Abort: MODE≠7 seen in RUN. Go to IDLE, drop `busy`, no `done`. The register performs the new MODE's operation on that same edge.
- In IDLE, modes 0–6 operate every cycle; the FSM is not involved.
- `busy` = (state==RUN). `done` is a registered single-cycle pulse.

## Timing
- Reset values: `parallel_Q`=0, `serial_Q`=0, `busy`=0, `done`=0, state=IDLE, count=0.
  - Reset takes effect immediately on `rst` falling, without waiting for a clock edge.
  - Reset wins over every mode, including mid-burst.
  - Release is synchronous to the next rising edge; the first operation happens on the first edge after `rst` goes high.
- Modes 0–6: single-cycle latency; the result is visible after the sampling edge.
- A burst of length N:
  - Start edge E0; shifts on E1..EN.
  - `busy` is high from after E0 until after EN.
  - `done` is high for the one cycle after EN.
- Counter width CNT_W must hold WIDTH. burst_len > WIDTH is allowed; it simply shifts more times.

## Structure
- Shared package `usr_pkg` holds:
  - The mode enum and its constants MODE_HOLD..MODE_BURST.
  - The burst state enum {IDLE, RUN, WAIT}.
- Sub-module `usr_burst_ctrl` holds the FSM, counter and the busy/done outputs.
  - It outputs a `burst_shift` strobe.
  - The top module keeps the register, the next-value mux and `serial_Q`.

## Test plan
All scenarios use WIDTH=8.
1. LOAD 8'hA5, then drive `rst` low between clock edges → `parallel_Q`=8'h00 and `serial_Q`=0 immediately. After release, HOLD keeps 8'h00.
2. LOAD 8'h81, then SHL with serial_in_l=0 for 3 cycles → 8'h02, 8'h04, 8'h08. `serial_Q` reads 1, 0, 0 after each edge.
3. LOAD 8'h81, then ROR for 1 cycle → 8'hC0 and `serial_Q`=1. Then ROL for 1 cycle → 8'h81 and `serial_Q`=1.
4. LOAD 8'h90, then ASR for 2 cycles → 8'hC8, then 8'hE4. Then SHR with serial_in_r=0 for 1 cycle → 8'h72.
5. LOAD 8'hF0, then BURST with burst_len=3 and serial_in_r=1, MODE held at 7:
   - `busy` is high for 3 cycles and the result is 8'hFE with `serial_Q`=0.
   - `done` is high for exactly 1 cycle.
   - The register holds while MODE stays 7.
   - Dropping to HOLD and then returning to 7 starts a new burst.
6. Edge cases:
   - burst_len=0 → `done` pulses with no shift and `busy` never rises.
   - burst_len=5 aborted after 2 shifts by LOAD 8'h3C → `parallel_Q`=8'h3C, `busy`=0, and no `done` pulse.
